// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU engine that owns HI/LO,
// with MFHI/MFLO reads and MTHI/MTLO writes for the EX stage.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDOP,
    input  logic        Start,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOUT
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CLOG_W     = $clog2(MAX_CYCLES + 1);
    localparam int unsigned CNT_W      = (CLOG_W < 4) ? 4 : CLOG_W;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        tmp_hi;
    logic [31:0]        tmp_lo;
    logic               tmp_dz;

    logic [63:0]        prod;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               res_dz;
    logic               is_mdop;
    logic               is_div;
    logic               launch;

    assign is_mdop = (MDOP == OP_MULT) || (MDOP == OP_MULTU) ||
                     (MDOP == OP_DIV)  || (MDOP == OP_DIVU);
    assign is_div  = (MDOP == OP_DIV)  || (MDOP == OP_DIVU);
    assign launch  = Start && !Req && is_mdop;

    // Result of the selected operation, computed from the current operands
    always_comb begin
        prod   = 64'd0;
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_dz = 1'b0;
        case (MDOP)
            OP_MULT: begin
                prod   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            OP_MULTU: begin
                prod   = {32'd0, A} * {32'd0, B};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            OP_DIV: begin
                if (B == 32'd0) begin
                    res_dz = 1'b1;
                end else if ((A == 32'h8000_0000) && (B == 32'hFFFF_FFFF)) begin
                    // Quotient overflows back to the most negative value
                    res_lo = 32'h8000_0000;
                    res_hi = 32'd0;
                end else begin
                    res_lo = 32'($signed(A) / $signed(B));
                    res_hi = 32'($signed(A) % $signed(B));
                end
            end
            OP_DIVU: begin
                if (B == 32'd0) begin
                    res_dz = 1'b1;
                end else begin
                    res_lo = A / B;
                    res_hi = A % B;
                end
            end
            default: begin
                res_dz = 1'b0;
            end
        endcase
    end

    // Control FSM, latency counter, result holds and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            tmp_hi <= 32'd0;
            tmp_lo <= 32'd0;
            tmp_dz <= 1'b0;
            Busy   <= 1'b0;
            HI     <= 32'd0;
            LO     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        tmp_hi <= res_hi;
                        tmp_lo <= res_lo;
                        tmp_dz <= res_dz;
                        cnt    <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        Busy   <= 1'b1;
                        state  <= RUN;
                    end else if (!Req && (MDOP == OP_MTHI)) begin
                        HI <= A;
                    end else if (!Req && (MDOP == OP_MTLO)) begin
                        LO <= A;
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (!tmp_dz) begin
                            HI <= tmp_hi;
                            LO <= tmp_lo;
                        end
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    // Architectural read port for MFHI/MFLO
    always_comb begin
        MDOUT = 32'd0;
        if (MDOP == OP_MFHI) begin
            MDOUT = HI;
        end else if (MDOP == OP_MFLO) begin
            MDOUT = LO;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against an arithmetic HI/LO model.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  mdop;
    logic        start;
    logic        req;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdout;

    int checks = 0;
    int errors = 0;

    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (a),
        .B     (b),
        .MDOP  (mdop),
        .Start (start),
        .Req   (req),
        .Busy  (busy),
        .HI    (hi),
        .LO    (lo),
        .MDOUT (mdout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural effect of a completed operation on HI/LO
    function automatic void model(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                                  inout logic [31:0] h, inout logic [31:0] l);
        longint sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (op)
            4'd1: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            4'd2: begin up = {32'd0, av} * {32'd0, bv}; h = up[63:32]; l = up[31:0]; end
            4'd3: if (bv != 32'd0) begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
            4'd4: if (bv != 32'd0) begin l = av / bv; h = av % bv; end
            default: ;
        endcase
    endfunction

    // Launch one operation (caller sits at a negedge) and follow it to completion
    task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv, input int inj);
        int k;
        int n;
        mdop = op; a = av; b = bv; start = 1'b1; req = 1'b0;
        @(negedge clk);
        start = 1'b0; mdop = 4'd0; a = $urandom; b = $urandom;
        k = 0;
        while (busy === 1'b1 && k < 40) begin
            checks++;
            if (hi !== hi_m || lo !== lo_m) begin
                errors++;
                $display("FAIL hold_while_busy op=%0d cyc=%0d hi=%h lo=%h exp hi=%h lo=%h", op, k, hi, lo, hi_m, lo_m);
            end
            if (inj != 0 && k == inj) begin start = 1'b1; mdop = 4'd1; end
            if (inj != 0 && k == inj + 1) begin start = 1'b0; mdop = 4'd8; a = 32'd5; end
            if (inj != 0 && k == inj + 2) begin mdop = 4'd0; end
            k++;
            @(negedge clk);
        end
        mdop = 4'd0; start = 1'b0;
        n = (op == 4'd3 || op == 4'd4) ? 10 : 5;
        checks++;
        if (k != n) begin
            errors++;
            $display("FAIL busy_len op=%0d got %0d exp %0d", op, k, n);
        end
        model(op, av, bv, hi_m, lo_m);
        checks++;
        if (hi !== hi_m || lo !== lo_m) begin
            errors++;
            $display("FAIL result op=%0d a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h", op, av, bv, hi, lo, hi_m, lo_m);
        end
    endtask

    // Present an MTHI/MTLO for one cycle
    task automatic do_move(input logic [3:0] op, input logic [31:0] v, input logic r);
        mdop = op; a = v; req = r;
        @(negedge clk);
        mdop = 4'd0; req = 1'b0;
        if (!r) begin
            if (op == 4'd7) hi_m = v;
            else lo_m = v;
        end
        checks++;
        if (hi !== hi_m || lo !== lo_m) begin
            errors++;
            $display("FAIL move op=%0d req=%0d got hi=%h lo=%h exp hi=%h lo=%h", op, r, hi, lo, hi_m, lo_m);
        end
    endtask

    // MFHI/MFLO read port and a non-read opcode
    task automatic check_reads();
        logic [3:0] other;
        mdop = 4'd5; #1;
        checks++;
        if (mdout !== hi_m) begin errors++; $display("FAIL mfhi got %h exp %h", mdout, hi_m); end
        mdop = 4'd6; #1;
        checks++;
        if (mdout !== lo_m) begin errors++; $display("FAIL mflo got %h exp %h", mdout, lo_m); end
        other = 4'($urandom_range(9, 15));
        mdop = other; #1;
        checks++;
        if (mdout !== 32'd0) begin errors++; $display("FAIL mdout_other op=%0d got %h exp 0", other, mdout); end
        mdop = 4'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset busy=%b hi=%h lo=%h exp 0 0 0", busy, hi, lo);
        end
        check_reads();
    endtask

    task automatic test_directed();
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 0);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_plan got %h_%h exp ffffffff_fffffffa", hi, lo); end
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 0);
        checks++;
        if (hi !== 32'd2 || lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_plan got %h_%h exp 00000002_fffffffa", hi, lo); end
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 0);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_plan got %h_%h exp ffffffff_fffffffd", hi, lo); end
        run_op(4'd4, 32'd7, 32'd2, 0);
        checks++;
        if (hi !== 32'd1 || lo !== 32'd3) begin errors++; $display("FAIL divu_plan got %h_%h exp 1_3", hi, lo); end
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        checks++;
        if (hi !== 32'd0 || lo !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow got %h_%h exp 0_80000000", hi, lo); end
    endtask

    task automatic test_divzero_moves();
        do_move(4'd7, 32'h1234_5678, 1'b0);
        do_move(4'd8, 32'h9ABC_DEF0, 1'b0);
        check_reads();
        run_op(4'd4, 32'd7, 32'd0, 0);
        run_op(4'd3, 32'hFFFF_0000, 32'd0, 0);
        checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin errors++; $display("FAIL divzero_keep got %h_%h exp 12345678_9abcdef0", hi, lo); end
        check_reads();
    endtask

    task automatic test_req();
        mdop = 4'd1; a = $urandom; b = $urandom; start = 1'b1; req = 1'b1;
        @(negedge clk);
        start = 1'b0; mdop = 4'd0; req = 1'b0;
        repeat (3) begin
            checks++;
            if (busy !== 1'b0 || hi !== hi_m || lo !== lo_m) begin
                errors++;
                $display("FAIL req_launch busy=%b hi=%h lo=%h exp 0 %h %h", busy, hi, lo, hi_m, lo_m);
            end
            @(negedge clk);
        end
        do_move(4'd8, 32'hCAFE_F00D, 1'b1);
        do_move(4'd7, 32'hBEEF_0001, 1'b1);
        // Start with a non-multiply opcode is not a launch
        mdop = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mdop = 4'd0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_bad_op busy=%b exp 0", busy); end
    endtask

    task automatic test_ignore_in_run();
        run_op(4'd3, 32'd1000, 32'hFFFF_FFF9, 3);
        run_op(4'd1, 32'h0001_0003, 32'h0002_0005, 2);
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] av, bv;
        int sel;
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(1, 4));
            av = $urandom; bv = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) bv = 32'd0;
            else if (sel == 1) begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
            else if (sel == 2) bv = 32'($urandom_range(1, 20));
            else if (sel == 3) bv = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
            run_op(op, av, bv, 0);
            if (sel == 4) do_move(4'($urandom_range(7, 8)), $urandom, 1'($urandom_range(0, 1)));
        end
        check_reads();
    endtask

    task automatic test_back_to_back();
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(4'd4, 32'hFFFF_FFFF, 32'd16, 0);
        run_op(4'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(4'd3, 32'd17, 32'hFFFF_FFFB, 0);
    endtask

    task automatic test_reset_mid();
        do_move(4'd7, 32'hDEAD_BEEF, 1'b0);
        do_move(4'd8, 32'h0BAD_F00D, 1'b0);
        mdop = 4'd1; a = 32'd1234; b = 32'd5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mdop = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d busy=%b hi=%h lo=%h exp 0 0 0", i, busy, hi, lo);
            end
            @(negedge clk);
        end
        run_op(4'd2, 32'd6, 32'd7, 0);
    endtask

    initial begin
        reset = 1'b1; a = 32'd0; b = 32'd0; mdop = 4'd0; start = 1'b0; req = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_divzero_moves();
        test_req();
        test_ignore_in_run();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit paired with the ALU in the EX stage of the pipelined MIPS core. It executes MULT/MULTU/DIV/DIVU over a fixed latency and owns the HI/LO registers. It also serves MFHI/MFLO reads and MTHI/MTLO writes. Its Busy output, together with Start, drives the hazard unit's stall for every later HI/LO-touching instruction.

## Interface
- MULT_CYCLES, 5: cycles Busy stays high for MULT/MULTU.
- DIV_CYCLES, 10: cycles Busy stays high for DIV/DIVU.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- A  in  32  rs operand, the dividend for divides.
- B  in  32  rt operand, the divisor for divides.
- MDOP  in  4  operation select: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9–15 behave as NONE.
- Start  in  1  single-cycle launch strobe, asserted together with MDOP 1–4.
- Req  in  1  exception/interrupt request for the instruction in EX; suppresses launches and writes from that instruction.
- Busy  out  1  operation in flight.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.
- MDOUT  out  32  combinational read: HI when MDOP=MFHI, LO when MDOP=MFLO, otherwise 0.

## Operation
- Internal state: HI, LO, result holds tmpHI/tmpLO, and a down-counter cnt (4 bits minimum, sized for max(MULT_CYCLES, DIV_CYCLES)).
- States: IDLE (Busy=0) and RUN (Busy=1).
- **Launch:** in IDLE, Start=1, Req=0 and MDOP∈{1..4}:
  - compute the result combinationally from A and B and register it into tmpHI/tmpLO;
  - load cnt with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- **Multiply results:**
  - MULT: {tmpHI,tmpLO} = $signed(A) × $signed(B), full 64-bit product.
  - MULTU: unsigned 64-bit product.
- **Divide results:**
  - DIV: tmpLO = signed quotient, truncated toward zero; tmpHI = signed remainder, same sign as the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0), DIV or DIVU: runs the full DIV_CYCLES, then HI and LO keep their prior values; tmp is not committed.
- **RUN:** cnt decrements every cycle. At the edge where cnt==1:
  - HI<=tmpHI and LO<=tmpLO, except for divide by zero;
  - Busy<=0, return to IDLE.
- **Moves:**
  - MTHI: HI<=A at the edge, only when IDLE and Req=0.
  - MTLO: LO<=A at the edge, only when IDLE and Req=0.
- **Ignored cases:**
  - Start or MTHI/MTLO while in RUN: ignored. The hazard unit guarantees these do not occur; the block still must not corrupt state.
  - Start with MDOP∉{1..4}: ignored.
- Req=1 while in RUN does not abort the in-flight operation; it belongs to an older, committed instruction.

## Timing
- Reset: HI=0, LO=0, Busy=0, cnt=0, tmpHI=tmpLO=0, state IDLE.
- Reset asserted mid-operation aborts it; no commit occurs.
- Launch at edge t: Busy is high for cycles t+1 … t+N, with N=MULT_CYCLES or DIV_CYCLES.
- At edge t+N: Busy falls and HI/LO update in the same edge. HI/LO are visible in cycle t+N+1.
- Back-to-back: a new Start is accepted in the first cycle Busy=0.
- HI/LO never change while Busy=1.
- MDOUT is purely combinational from MDOP, HI and LO; there is no bypass from tmp.
- MTHI/MTLO take effect one edge after they are presented; MDOUT reflects the new value on the next cycle.
- The stall condition seen by the hazard unit is Start|Busy; the block adds no extra cycle.

## Test plan
- MULT with A=0xFFFFFFFE, B=0x00000003, Start pulse → Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with the same A and B → HI=0x00000002, LO=0xFFFFFFFA after 5 cycles.
- DIV with A=0xFFFFFFF9, B=2 → after 10 Busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU with A=7, B=2 → LO=3, HI=1.
- MTHI A=0x12345678, MTLO A=0x9ABCDEF0, then DIVU with B=0 → Busy for 10 cycles, HI/LO unchanged. Then MDOP=MFHI → MDOUT=0x12345678; MDOP=MFLO → MDOUT=0x9ABCDEF0.
- Start MULT with Req=1 → Busy stays 0, HI/LO unchanged. MTLO with Req=1 → LO unchanged.
- Launch DIV, then during Busy present Start MULT and MTLO A=5 → both ignored, DIV result committed at cycle 10.
- Launch MULT, assert reset in Busy cycle 3 → next cycle Busy=0, HI=LO=0, no later commit.
